// File: rtl/spectral_flux_nband_if.sv
// Bin stream in, per-frame flux and onset pulses out.
// Signal names follow the block's external pin list.
interface spectral_flux_nband_if #(
  parameter int W         = 16,
  parameter int NUM_BANDS = 4,
  parameter int ACC_W     = 32
);
  logic                       mag_valid;
  logic [W-1:0]               mag_sq;
  logic                       frame_start;
  logic                       abs_mode;
  logic [ACC_W-1:0]           onset_thresh;
  logic [ACC_W-1:0]           flux_value;
  logic [NUM_BANDS*ACC_W-1:0] flux_band;
  logic                       flux_valid;
  logic                       beat_valid;
  logic                       flux_sat;
  logic                       frame_done;
  logic                       frame_err;

  modport master (
    output mag_valid, mag_sq, frame_start,
    output abs_mode, onset_thresh,
    input  flux_value, flux_band, flux_valid,
    input  beat_valid, flux_sat, frame_done,
    input  frame_err
  );

  modport slave (
    input  mag_valid, mag_sq, frame_start,
    input  abs_mode, onset_thresh,
    output flux_value, flux_band, flux_valid,
    output beat_valid, flux_sat, frame_done,
    output frame_err
  );
endinterface

// File: rtl/spectral_flux_nband.sv
// N-band spectral flux with previous-frame RAM, saturating
// accumulators, frame resync and onset detection.
module spectral_flux_nband #(
  parameter int W         = 16,
  parameter int N         = 1024,
  parameter int NUM_BANDS = 4,
  parameter int ACC_W     = 32
) (
  input logic clk,
  input logic reset,
  spectral_flux_nband_if.slave bus
);
  localparam int BW  = $clog2(N);
  localparam int SH  = BW - $clog2(NUM_BANDS);
  localparam int NBW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

  typedef logic [NUM_BANDS-1:0][ACC_W-1:0] bands_t;

  logic [W-1:0]     ram [N];
  logic [BW-1:0]    cnt_q, cnt_d, bin;
  logic             first, last;
  logic [NBW-1:0]   band;
  logic             primed_q, err_q;
  logic             abs_fr_q, abs_cur;
  logic [ACC_W-1:0] thr_fr_q, thr_cur;

  assign bin     = bus.frame_start ? '0 : cnt_q;
  assign cnt_d   = bin + BW'(1);
  assign first   = (bin == '0);
  assign last    = (bin == BW'(N - 1));
  assign band    = NBW'(bin >> SH);
  assign abs_cur = first ? bus.abs_mode : abs_fr_q;
  assign thr_cur = first ? bus.onset_thresh : thr_fr_q;

  // Stage 1: cur and prev. RAM read returns the pre-write word.
  logic [W-1:0]     a_cur_q, a_prev_q;
  logic             a_v_q, a_first_q, a_last_q;
  logic             a_abs_q, a_emit_q;
  logic [NBW-1:0]   a_band_q;
  logic [ACC_W-1:0] a_thr_q;

  always_ff @(posedge clk) begin
    if (bus.mag_valid) begin
      ram[bin] <= bus.mag_sq;
      a_prev_q <= ram[bin];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      primed_q  <= 1'b0;
      err_q     <= 1'b0;
      abs_fr_q  <= 1'b0;
      thr_fr_q  <= '0;
      a_v_q     <= 1'b0;
      a_first_q <= 1'b0;
      a_last_q  <= 1'b0;
      a_abs_q   <= 1'b0;
      a_emit_q  <= 1'b0;
      a_band_q  <= '0;
      a_thr_q   <= '0;
      a_cur_q   <= '0;
    end else begin
      a_v_q <= bus.mag_valid;
      err_q <= bus.mag_valid && bus.frame_start
               && (cnt_q != '0);
      if (bus.mag_valid) begin
        cnt_q     <= cnt_d;
        abs_fr_q  <= abs_cur;
        thr_fr_q  <= thr_cur;
        a_first_q <= first;
        a_last_q  <= last;
        a_abs_q   <= abs_cur;
        a_emit_q  <= primed_q;
        a_band_q  <= band;
        a_thr_q   <= thr_cur;
        a_cur_q   <= bus.mag_sq;
        if (last) primed_q <= 1'b1;
      end
    end
  end

  // Contribution from a (W+1)-bit signed difference.
  logic [W:0]   diff;
  logic         neg;
  logic [W-1:0] con;

  assign diff = {1'b0, a_cur_q} - {1'b0, a_prev_q};
  assign neg  = diff[W];

  always_comb begin
    con = diff[W-1:0];
    if (neg) con = a_abs_q ? W'(-diff) : '0;
  end

  logic             b_v_q, b_first_q, b_last_q, b_emit_q;
  logic [NBW-1:0]   b_band_q;
  logic [ACC_W-1:0] b_thr_q;
  logic [W-1:0]     b_con_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_v_q     <= 1'b0;
      b_first_q <= 1'b0;
      b_last_q  <= 1'b0;
      b_emit_q  <= 1'b0;
      b_band_q  <= '0;
      b_thr_q   <= '0;
      b_con_q   <= '0;
    end else begin
      b_v_q     <= a_v_q;
      b_first_q <= a_first_q;
      b_last_q  <= a_last_q;
      b_emit_q  <= a_emit_q;
      b_band_q  <= a_band_q;
      b_thr_q   <= a_thr_q;
      b_con_q   <= con;
    end
  end

  // Stage 2: saturating accumulate, cleared on bin 0.
  bands_t           acc_q, acc_d;
  logic [ACC_W-1:0] tot_q, tot_d;
  logic             sat_q, sat_d;
  logic [ACC_W:0]   tsum, bsum, ext;
  logic             c_last_q, c_emit_q;
  logic [ACC_W-1:0] c_thr_q;

  assign ext = (ACC_W + 1)'(b_con_q);

  always_comb begin
    acc_d = acc_q;
    tot_d = tot_q;
    sat_d = sat_q;
    tsum  = '0;
    bsum  = '0;
    if (b_v_q) begin
      if (b_first_q) begin
        acc_d = '0;
        tot_d = '0;
        sat_d = 1'b0;
      end
      tsum  = {1'b0, tot_d} + ext;
      bsum  = {1'b0, acc_d[b_band_q]} + ext;
      tot_d = tsum[ACC_W] ? '1 : tsum[ACC_W-1:0];
      acc_d[b_band_q] = bsum[ACC_W] ? '1 : bsum[ACC_W-1:0];
      sat_d = sat_d | tsum[ACC_W] | bsum[ACC_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      tot_q    <= '0;
      sat_q    <= 1'b0;
      c_last_q <= 1'b0;
      c_emit_q <= 1'b0;
      c_thr_q  <= '0;
    end else begin
      acc_q    <= acc_d;
      tot_q    <= tot_d;
      sat_q    <= sat_d;
      c_last_q <= b_v_q && b_last_q;
      c_emit_q <= b_emit_q;
      c_thr_q  <= b_thr_q;
    end
  end

  // Stage 3: output registers and onset compare.
  logic             emit;
  logic [ACC_W-1:0] fv_q, prev_q;
  bands_t           fb_q;
  logic             dv_q, done_q, beat_q, fsat_q;

  assign emit = c_last_q && c_emit_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fv_q   <= '0;
      fb_q   <= '0;
      prev_q <= '0;
      dv_q   <= 1'b0;
      done_q <= 1'b0;
      beat_q <= 1'b0;
      fsat_q <= 1'b0;
    end else begin
      dv_q   <= emit;
      done_q <= c_last_q;
      fsat_q <= emit && sat_q;
      beat_q <= emit && (tot_q > c_thr_q)
                && (tot_q > prev_q);
      if (emit) begin
        fv_q   <= tot_q;
        fb_q   <= acc_q;
        prev_q <= tot_q;
      end
    end
  end

  assign bus.flux_value = fv_q;
  assign bus.flux_band  = fb_q;
  assign bus.flux_valid = dv_q;
  assign bus.beat_valid = beat_q;
  assign bus.flux_sat   = fsat_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;
endmodule

// File: tb/tb_spectral_flux_nband.sv
// Bench: two instances (ACC_W 32 and 16) on one bin stream,
// checked each cycle against a frame-level reference model.
module tb_spectral_flux_nband;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  spectral_flux_nband_if #(.W(16), .NUM_BANDS(4), .ACC_W(32)) b32();
  spectral_flux_nband_if #(.W(16), .NUM_BANDS(4), .ACC_W(16)) b16();

  spectral_flux_nband #(.W(16), .N(8), .NUM_BANDS(4), .ACC_W(32))
    u32 (.clk(clk), .reset(reset), .bus(b32));
  spectral_flux_nband #(.W(16), .N(8), .NUM_BANDS(4), .ACC_W(16))
    u16 (.clk(clk), .reset(reset), .bus(b16));

  int checks = 0;
  int errors = 0;

  // reference model state
  int          pos = 0;
  bit          primed = 0;
  bit          fabs;
  logic [31:0] fthr;
  longint      tot;
  longint      bs [4];
  int          prevf [8];
  logic [31:0] pe32 = 0;
  logic [15:0] pe16 = 0;
  bit          cur_abs = 0;
  logic [31:0] cur_thr = 0;

  // expected events keyed by the edge after which they show
  bit           exp_fv [int];
  bit           exp_done [int];
  bit           exp_err [int];
  bit           exp_beat32 [int];
  bit           exp_beat16 [int];
  bit           exp_sat32 [int];
  bit           exp_sat16 [int];
  logic [31:0]  exp_v32 [int];
  logic [127:0] exp_b32 [int];
  logic [15:0]  exp_v16 [int];
  logic [63:0]  exp_b16 [int];
  logic [31:0]  h32 = 0;
  logic [127:0] hb32 = 0;
  logic [15:0]  h16 = 0;
  logic [63:0]  hb16 = 0;

  int flat [8] = '{200, 200, 200, 200, 200, 200, 200, 200};
  int ramp [8] = '{100, 120, 140, 160, 180, 200, 220, 240};
  int pat  [8] = '{100, 700, 1400, 100, 700, 1400, 100, 700};
  int zer  [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
  int ones [8] = '{65535, 65535, 65535, 65535,
                   65535, 65535, 65535, 65535};

  task automatic check(string tag, logic [127:0] obs,
                       logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int edge_now();
    return int'(($time - 5) / 10);
  endfunction

  task automatic emit(int k);
    longint m32, m16, bb;
    logic [31:0] v32;
    logic [15:0] v16;
    logic [127:0] p32;
    logic [63:0] p16;
    bit s32, s16;
    m32 = 64'hFFFF_FFFF;
    m16 = 65535;
    v32 = (tot > m32) ? m32[31:0] : tot[31:0];
    v16 = (tot > m16) ? m16[15:0] : tot[15:0];
    s32 = tot > m32;
    s16 = tot > m16;
    for (int i = 0; i < 4; i++) begin
      bb = (bs[i] > m32) ? m32 : bs[i];
      p32[i*32 +: 32] = bb[31:0];
      bb = (bs[i] > m16) ? m16 : bs[i];
      p16[i*16 +: 16] = bb[15:0];
      s32 |= bs[i] > m32;
      s16 |= bs[i] > m16;
    end
    exp_fv[k]  = 1;
    exp_v32[k] = v32;
    exp_b32[k] = p32;
    exp_v16[k] = v16;
    exp_b16[k] = p16;
    if (s32) exp_sat32[k] = 1;
    if (s16) exp_sat16[k] = 1;
    if (v32 > fthr && v32 > pe32) exp_beat32[k] = 1;
    if (v16 > fthr[15:0] && v16 > pe16) exp_beat16[k] = 1;
    pe32 = v32;
    pe16 = v16;
  endtask

  task automatic model_bin(int e, bit fs, int v);
    int d, c;
    if (fs && pos != 0) exp_err[e] = 1;
    if (fs) pos = 0;
    if (pos == 0) begin
      fabs = cur_abs;
      fthr = cur_thr;
      tot = 0;
      for (int i = 0; i < 4; i++) bs[i] = 0;
    end
    d = v - prevf[pos];
    c = (d < 0) ? (fabs ? -d : 0) : d;
    tot += c;
    bs[pos / 2] += c;
    prevf[pos] = v;
    if (pos == 7) begin
      exp_done[e + 3] = 1;
      if (primed) emit(e + 3);
      primed = 1;
    end
    pos = (pos + 1) % 8;
  endtask

  task automatic model_reset();
    pos = 0;
    primed = 0;
    pe32 = 0;
    pe16 = 0;
    h32 = 0;
    hb32 = 0;
    h16 = 0;
    hb16 = 0;
    exp_fv.delete();
    exp_done.delete();
    exp_err.delete();
    exp_beat32.delete();
    exp_beat16.delete();
    exp_sat32.delete();
    exp_sat16.delete();
    exp_v32.delete();
    exp_b32.delete();
    exp_v16.delete();
    exp_b16.delete();
  endtask

  always @(negedge clk) begin : mon
    int e;
    e = int'($time / 10) - 1;
    if (e >= 0) begin
      if (exp_fv.exists(e)) begin
        h32  = exp_v32[e];
        hb32 = exp_b32[e];
        h16  = exp_v16[e];
        hb16 = exp_b16[e];
      end
      check("valid32", b32.flux_valid, exp_fv.exists(e));
      check("valid16", b16.flux_valid, exp_fv.exists(e));
      check("done32", b32.frame_done, exp_done.exists(e));
      check("done16", b16.frame_done, exp_done.exists(e));
      check("err32", b32.frame_err, exp_err.exists(e));
      check("err16", b16.frame_err, exp_err.exists(e));
      check("beat32", b32.beat_valid, exp_beat32.exists(e));
      check("beat16", b16.beat_valid, exp_beat16.exists(e));
      check("sat32", b32.flux_sat, exp_sat32.exists(e));
      check("sat16", b16.flux_sat, exp_sat16.exists(e));
      check("value32", b32.flux_value, h32);
      check("value16", b16.flux_value, h16);
      check("bands32", b32.flux_band, hb32);
      check("bands16", b16.flux_band, hb16);
    end
  end

  task automatic drive(bit fs, int v);
    b32.mag_valid    = 1'b1;
    b16.mag_valid    = 1'b1;
    b32.frame_start  = fs;
    b16.frame_start  = fs;
    b32.mag_sq       = 16'(v);
    b16.mag_sq       = 16'(v);
    b32.abs_mode     = cur_abs;
    b16.abs_mode     = cur_abs;
    b32.onset_thresh = cur_thr;
    b16.onset_thresh = cur_thr[15:0];
    @(posedge clk);
    model_bin(edge_now(), fs, v);
    #1;
    b32.mag_valid   = 1'b0;
    b16.mag_valid   = 1'b0;
    b32.frame_start = 1'b0;
    b16.frame_start = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input int v [8], input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps && $urandom_range(0, 3) == 0)
        idle($urandom_range(1, 2));
      drive(i == 0, v[i]);
    end
  endtask

  task automatic settle();
    idle(3);
  endtask

  initial begin
    int rv [8];
    int plen;
    b32.mag_valid = 0; b16.mag_valid = 0;
    b32.frame_start = 0; b16.frame_start = 0;
    b32.mag_sq = 0; b16.mag_sq = 0;
    b32.abs_mode = 0; b16.abs_mode = 0;
    b32.onset_thresh = 0; b16.onset_thresh = 0;
    for (int i = 0; i < 8; i++) prevf[i] = 0;

    repeat (3) @(negedge clk);
    check("rst_value", b32.flux_value, 0);
    check("rst_bands", b32.flux_band, 0);
    check("rst_valid", b32.flux_valid, 0);
    check("rst_done", b32.frame_done, 0);
    reset = 1'b1;
    idle(2);

    // priming then ramp
    cur_thr = 1000;
    frame(flat, 0);
    frame(ramp, 0);
    settle();
    check("s1_value", b32.flux_value, 60);
    check("s1_bands", b32.flux_band,
          {32'd60, 32'd0, 32'd0, 32'd0});

    // absolute mode
    cur_abs = 1;
    frame(flat, 0);
    frame(ramp, 0);
    settle();
    check("s2_value", b32.flux_value, 360);
    check("s2_bands", b32.flux_band,
          {32'd60, 32'd20, 32'd100, 32'd180});

    // band pattern and onset
    cur_abs = 0;
    frame(ramp, 0);
    frame(pat, 0);
    settle();
    check("s3_value", b32.flux_value, 4020);
    check("s3_bands", b32.flux_band,
          {32'd460, 32'd1720, 32'd1260, 32'd580});
    check("s3_beat", b32.beat_valid, 1);
    frame(pat, 0);
    settle();
    check("s3_rep_value", b32.flux_value, 0);
    check("s3_rep_beat", b32.beat_valid, 0);

    // saturation
    frame(zer, 0);
    frame(ones, 0);
    settle();
    check("s4_value16", b16.flux_value, 16'hFFFF);
    check("s4_sat16", b16.flux_sat, 1);
    check("s4_bands16", b16.flux_band, 64'hFFFF_FFFF_FFFF_FFFF);
    check("s4_value32", b32.flux_value, 32'd524280);

    // resync on bin 3
    for (int i = 0; i < 3; i++) drive(i == 0, ramp[i]);
    drive(1, pat[0]);
    check("s5_err", b32.frame_err, 1);
    for (int i = 1; i < 8; i++) drive(0, pat[i]);
    idle(2);
    check("s5_early", b32.flux_valid, 0);
    idle(1);
    check("s5_valid", b32.flux_valid, 1);

    // reset mid-frame
    for (int i = 0; i < 5; i++) drive(i == 0, ramp[i]);
    reset = 1'b0;
    model_reset();
    #1;
    check("s6_value", b32.flux_value, 0);
    check("s6_bands", b32.flux_band, 0);
    check("s6_value16", b16.flux_value, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    frame(ramp, 0);
    frame(pat, 0);
    settle();
    check("s6_after", b32.flux_value, 4020);

    // randomized frames, gaps, resyncs, mid-frame control changes
    for (int f = 0; f < 40; f++) begin
      cur_abs = 1'($urandom_range(0, 1));
      cur_thr = $urandom_range(0, 300000);
      if ($urandom_range(0, 4) == 0) begin
        plen = $urandom_range(1, 7);
        for (int i = 0; i < plen; i++)
          drive(i == 0, $urandom_range(0, 65535));
      end
      for (int i = 0; i < 8; i++)
        rv[i] = (f % 3 == 0) ? $urandom_range(0, 3000)
                             : $urandom_range(0, 65535);
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        drive(i == 0, rv[i]);
        cur_abs = 1'($urandom_range(0, 1));
        cur_thr = $urandom_range(0, 300000);
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
